sound_sequencer: RTL and testbench

Step sequencer that drives the sound generator: produces its free-running `sample_strobe` and schedules its 4-bit tone-enable `control` mask from a small writable step table. Each step holds a channel mask and a duration in ticks; the sequencer plays steps in order, ends or loops at an end marker, and handles start/stop from the host logic. It sits between the system clock domain and the sound generator's strobe/control inputs.

---
 rtl/sound_pkg.sv | 20 ++
 rtl/strobe_div.sv | 28 ++
 rtl/sound_sequencer.sv | 148 ++++++++++++++
 tb/tb_sound_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types for the sound step sequencer.
// Step entry layout, FSM states and field widths.
package sound_pkg;

  localparam int MASK_W  = 4;
  localparam int TICKS_W = 8;
  localparam int ENTRY_W = MASK_W + TICKS_W;

  typedef struct packed {
    logic [MASK_W-1:0]  mask;
    logic [TICKS_W-1:0] ticks;
  } step_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/strobe_div.sv
// Free-running sample strobe divider.
// Pulses sample_strobe once every CLK_DIV clocks.
module strobe_div #(
  parameter int CLK_DIV = 2267
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_strobe
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sample_strobe = (cnt_q == LAST);

endmodule

// File: rtl/sound_sequencer.sv
// Step-table sequencer feeding the sound generator strobe/control.
// Define SOUND_SEQ_LOOP_EN for continuous looped playback.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_DIV          = 2267,
  parameter int SAMPLES_PER_TICK = 5512,
  parameter int STEPS            = 16,
  localparam int IDX_W           = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               sample_strobe,
  output logic [MASK_W-1:0]  control,
  output logic               busy,
  output logic [IDX_W-1:0]   step_idx,
  output logic               done
);

  localparam int SW = (SAMPLES_PER_TICK > 1) ?
                      $clog2(SAMPLES_PER_TICK) : 1;
  localparam logic [SW-1:0]    SLAST = SW'(SAMPLES_PER_TICK - 1);
  localparam logic [IDX_W-1:0] ILAST = IDX_W'(STEPS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MASK_W-1:0]   ctrl_q, ctrl_d;
  logic [TICKS_W-1:0]  rem_q, rem_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic                done_q, done_d;
  step_t               table_q [STEPS];
  step_t               table_d [STEPS];
  step_t               entry;
  logic                eos;

  strobe_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe)
  );

  always_comb begin
    table_d = table_q;
    if (wr_en) table_d[wr_addr] = step_t'(wr_data);
  end

  assign entry = table_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ctrl_d  = ctrl_q;
    rem_d   = rem_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    eos     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (entry.ticks == '0) begin
          eos = 1'b1;
        end else begin
          ctrl_d  = entry.mask;
          rem_d   = entry.ticks;
          scnt_d  = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (sample_strobe) begin
          if (scnt_q == SLAST) begin
            scnt_d = '0;
            rem_d  = rem_q - TICKS_W'(1);
            if (rem_q == TICKS_W'(1)) begin
              if (idx_q == ILAST) begin
                eos = 1'b1;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = LOAD;
              end
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (eos) begin
      done_d = 1'b1;
      idx_d  = '0;
`ifdef SOUND_SEQ_LOOP_EN
      // a marker at step 0 would spin forever, so it still ends
      if (state_q == PLAY || idx_q != '0) begin
        state_d = LOAD;
      end else begin
        state_d = IDLE;
        ctrl_d  = '0;
      end
`else
      state_d = IDLE;
      ctrl_d  = '0;
`endif
    end
    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
      ctrl_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ctrl_q  <= '0;
      rem_q   <= '0;
      scnt_q  <= '0;
      done_q  <= 1'b0;
      table_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      rem_q   <= rem_d;
      scnt_q  <= scnt_d;
      done_q  <= done_d;
      table_q <= table_d;
    end
  end

  assign control  = ctrl_q;
  assign busy     = (state_q != IDLE);
  assign step_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer (CLK_DIV=4, 2 samples/tick).
// Honours SOUND_SEQ_LOOP_EN for the looped-playback expectations.
module tb_sound_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        sample_strobe;
  logic [3:0]  control;
  logic        busy;
  logic [3:0]  step_idx;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  sound_sequencer #(
    .CLK_DIV          (4),
    .SAMPLES_PER_TICK (2),
    .STEPS            (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .sample_strobe (sample_strobe),
    .control       (control),
    .busy          (busy),
    .step_idx      (step_idx),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    cycles(1);
    wr_en   = 1'b0;
  endtask

  task automatic align();
    int n;
    n = 0;
    while (!sample_strobe && n < 8) begin
      cycles(1);
      n++;
    end
    check("align_strobe", 32'(sample_strobe), 32'd1);
  endtask

  function automatic logic [3:0] mk(input int k);
    logic [3:0] v;
    v = 4'(k);
    return v ^ 4'h6;
  endfunction

  initial begin
    int c3, c8, lowb, done_at, dn;

    // reset state and first strobe
    cycles(2);
    check("rst_strobe", 32'(sample_strobe), 0);
    check("rst_control", 32'(control), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    cycles(2);
    check("first_strobe_early", 32'(sample_strobe), 0);
    cycles(1);
    check("first_strobe", 32'(sample_strobe), 1);

    // empty table: marker at step 0
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("empty_busy_load", 32'(busy), 1);
    cycles(1);
    check("empty_done", 32'(done), 1);
    check("empty_control", 32'(control), 0);
    check("empty_busy_idle", 32'(busy), 0);
    cycles(1);
    check("empty_done_drop", 32'(done), 0);

    // program {0011,2},{1000,1},{0000,0}
    wr(0, 12'h302);
    wr(1, 12'h801);
    wr(2, 12'h000);
    align();
    start = 1'b1;
    c3 = 0; c8 = 0; lowb = 0; done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cycles(1);
      start = 1'b0;
      if (control == 4'h3) c3++;
      if (control == 4'h8) c8++;
      if (!busy) lowb++;
      if (done && done_at < 0) done_at = k;
    end
    check("prog_done_at", 32'(done_at), 26);
`ifdef SOUND_SEQ_LOOP_EN
    check("prog_cyc_0011", 32'(c3), 20);
    check("prog_cyc_1000", 32'(c8), 9);
    check("prog_busy_low", 32'(lowb), 0);
`else
    check("prog_cyc_0011", 32'(c3), 16);
    check("prog_cyc_1000", 32'(c8), 8);
    check("prog_busy_low", 32'(lowb), 5);
`endif
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("prog_stop_busy", 32'(busy), 0);

    // stop mid step 0
    align();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(4);
    check("stop_pre_control", 32'(control), 3);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("stop_control", 32'(control), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_idx", 32'(step_idx), 0);
    dn = 0; lowb = 0;
    for (int k = 0; k < 40; k++) begin
      cycles(1);
      if (done) dn++;
      if (busy) lowb++;
    end
    check("stop_no_done", 32'(dn), 0);
    check("stop_stays_idle", 32'(lowb), 0);
    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    cycles(2);
    check("startstop_busy2", 32'(busy), 0);
    check("startstop_done", 32'(done), 0);

    // 16 steps of one tick each
    for (int k = 0; k < 16; k++) wr(k, {mk(k), 8'd1});
    align();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(4);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("seq_ctrl_%0d", k), 32'(control), 32'(mk(k)));
      check($sformatf("seq_idx_%0d", k), 32'(step_idx), 32'(k));
      if (k == 1) begin
        wr(1, 12'hF01);
        cycles(7);
      end else if (k == 15) begin
        cycles(4);
      end else begin
        cycles(8);
      end
    end
    check("seq_done", 32'(done), 1);
`ifdef SOUND_SEQ_LOOP_EN
    check("seq_done_busy", 32'(busy), 1);
    cycles(12);
`else
    check("seq_done_busy", 32'(busy), 0);
    check("seq_done_ctrl", 32'(control), 0);
    align();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(12);
`endif
    check("rewrite_ctrl", 32'(control), 32'hF);
    check("rewrite_idx", 32'(step_idx), 1);

    // reset during playback
    cycles(4);
    rst_n = 1'b0;
    #1;
    check("arst_control", 32'(control), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_idx", 32'(step_idx), 0);
    check("arst_done", 32'(done), 0);
    check("arst_strobe", 32'(sample_strobe), 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    check("arst_strobe_early", 32'(sample_strobe), 0);
    cycles(1);
    check("arst_first_strobe", 32'(sample_strobe), 1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("arst_load", 32'(busy), 1);
    cycles(1);
    check("arst_table_clear", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
